// File: rtl/UART_pkg.sv
// Shared UART types and constants: byte type, TX FIFO depth, drain FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package UART_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int UART_TX_FIFO_DEPTH   = 16;
  localparam int UART_TX_BUSY_TIMEOUT = 4;

  typedef logic [UART_DATA_W-1:0] uart_data_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2
  } uart_tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake plus UART-core transmit signals of the TX FIFO.
// Latency: n/a (wires only).
// Backpressure: in_ready from the slave throttles the producer's in_valid.
interface uart_tx_fifo_if
  import UART_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_TX_FIFO_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] uart_tx_data;
  logic              uart_tx_send;
  logic              uart_tx_data_ready;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;

  // Producer / UART-core side of the block.
  modport master (
    output flush, in_data, in_valid, uart_tx_data_ready,
    input  in_ready, uart_tx_data, uart_tx_send, count, empty, full
  );

  // The TX FIFO itself.
  modport slave (
    input  flush, in_data, in_valid, uart_tx_data_ready,
    output in_ready, uart_tx_data, uart_tx_send, count, empty, full
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO: memory, wrapping pointers, occupancy count, full/empty.
// Latency: write visible at head one cycle after push; rd_data_o is combinational head.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module uart_sync_fifo
  import UART_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_TX_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o && !flush_i;
  assign do_pop    = pop_i && !empty_o && !flush_i;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next pointers and count; flush clears everything, pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer bytes and drains them to the UART core, one send pulse per byte.
// Latency: >=1 cycle push-to-pop, send pulse the cycle after pop; >=3 cycles between pulses.
// Backpressure: in_ready low when full, in reset or flushing; drain waits on tx_data_ready.
module uart_tx_fifo
  import UART_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int DEPTH        = UART_TX_FIFO_DEPTH,
  parameter int BUSY_TIMEOUT = UART_TX_BUSY_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TMO_W  = $clog2(BUSY_TIMEOUT + 1);

  uart_tx_fifo_state_t state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                push, pop;
  logic [DATA_W-1:0]   head;
  logic [ADDR_W:0]     fifo_count;
  logic                fifo_full, fifo_empty;

  assign bus.in_ready     = !fifo_full && !rst && !bus.flush;
  assign push             = bus.in_valid && bus.in_ready;
  assign bus.uart_tx_send = (state_q == SEND);
  assign bus.uart_tx_data = tx_data_q;
  assign bus.count        = fifo_count;
  assign bus.empty        = fifo_empty;
  assign bus.full         = fifo_full;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (bus.flush),
    .push_i    (push),
    .wr_data_i (bus.in_data),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Drain FSM: pop on IDLE->SEND, pulse for one cycle, then wait for the UART to go busy.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.uart_tx_data_ready && !bus.flush) begin
          pop       = 1'b1;
          tx_data_d = head;
          state_d   = SEND;
        end
      end
      SEND: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        tmo_d = tmo_q + 1'b1;
        // A UART that never reports busy must not stall the drain forever.
        if (!bus.uart_tx_data_ready || (tmo_q == TMO_W'(BUSY_TIMEOUT - 1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // FSM, timeout counter and held output byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule
